// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: operand/product valid-ready bundle for booth_mult_seq.
// acc_in is present only when BOOTH_MAC_EN is defined.
interface booth_mult_seq_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
`ifdef BOOTH_MAC_EN
   logic [2*WIDTH-1:0]   acc_in;
`endif
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

`ifdef BOOTH_MAC_EN
   modport master (
      output in_valid, a, b, acc_in, out_ready,
      input  in_ready, out_valid, p, busy
   );
   modport slave (
      input  in_valid, a, b, acc_in, out_ready,
      output in_ready, out_valid, p, busy
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier, one digit per clock.
// Optional BOOTH_MAC_EN: accumulator seeded from acc_in (p = a*b + acc_in).
module booth_mult_seq #(
   parameter int WIDTH = 16
) (
   input logic             clk,
   input logic             rst,
   booth_mult_seq_if.slave bus
);
   localparam int PW = 2*WIDTH;
   localparam int AW = PW + 1;
   localparam int CW = $clog2(WIDTH/2) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH/2 - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic signed [AW-1:0] acc, areg, pp, sum, acc_init;
   logic [WIDTH:0]       breg;
   logic [CW-1:0]        count;
   logic [PW-1:0]        p_q;
   logic                 accept, last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      last          = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (count == LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef BOOTH_MAC_EN
   assign acc_init = {bus.acc_in[PW-1], bus.acc_in};
`else
   assign acc_init = '0;
`endif

   // areg already carries the 4^i weight, so the triplet picks a multiple of it
   always_comb begin
      pp = '0;
      unique case (breg[2:0])
         3'b001, 3'b010: pp = areg;
         3'b011:         pp = areg <<< 1;
         3'b100:         pp = -(areg <<< 1);
         3'b101, 3'b110: pp = -areg;
         default:        pp = '0;
      endcase
   end

   assign sum = acc + pp;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         areg  <= '0;
         breg  <= '0;
         count <= '0;
         p_q   <= '0;
      end else if (accept) begin
         acc   <= acc_init;
         areg  <= {{(WIDTH+1){bus.a[WIDTH-1]}}, bus.a};
         breg  <= {bus.b, 1'b0};
         count <= '0;
      end else if (state == RUN) begin
         acc   <= sum;
         areg  <= areg <<< 2;
         breg  <= breg >> 2;
         count <= count + 1'b1;
         if (last) p_q <= sum[PW-1:0];
      end
   end

   assign bus.p = p_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: random and directed products against an arithmetic model.
// Covers WIDTH=16 and WIDTH=8 instances, handshake timing and mid-run reset.
`timescale 1ns/1ps
module tb_booth_mult_seq;
   localparam int W  = 16;
   localparam int W8 = 8;
`ifdef BOOTH_MAC_EN
   localparam bit MAC = 1'b1;
`else
   localparam bit MAC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [2*W-1:0] acc_v;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDTH(W))  bus ();
   booth_mult_seq_if #(.WIDTH(W8)) bus8 ();

   booth_mult_seq #(.WIDTH(W))  dut  (.clk(clk), .rst(rst), .bus(bus));
   booth_mult_seq #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [2*W-1:0] acc);
      longint r;
      r = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(acc));
      return r[2*W-1:0];
   endfunction

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit keep);
      logic [2*W-1:0] exp;
      int edges;
      exp = model(a, b, MAC ? acc_v : '0);
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
`ifdef BOOTH_MAC_EN
      bus.acc_in = acc_v;
`endif
      check("idle_rdy", bus.in_ready, 1);
      @(posedge clk); #1;
      check("run_busy", {bus.busy, bus.in_ready}, 2'b10);
      if (keep) begin
         bus.a = W'($urandom);
         bus.b = W'($urandom);
      end else begin
         bus.in_valid = 1'b0;
      end
      edges = 0;
      while (!bus.out_valid && edges < 64) begin
         @(posedge clk); #1;
         edges++;
         if (!bus.out_valid)
            check("run_rdy", {bus.busy, bus.in_ready}, 2'b10);
      end
      check("latency", edges, W/2);
      check("prod", bus.p, exp);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold", {bus.out_valid, bus.in_ready, bus.busy, bus.p},
               {3'b100, exp});
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("back_idle", {bus.out_valid, bus.in_ready, bus.busy, bus.p},
            {3'b010, exp});
   endtask

   task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b);
      logic [2*W8-1:0] exp;
      longint r;
      int edges;
      r = longint'($signed(a)) * longint'($signed(b));
      exp = r[2*W8-1:0];
      bus8.a = a;
      bus8.b = b;
      bus8.in_valid = 1'b1;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      edges = 0;
      while (!bus8.out_valid && edges < 64) begin
         @(posedge clk); #1;
         edges++;
      end
      check("w8_latency", edges, W8/2);
      check("w8_prod", bus8.p, exp);
      @(posedge clk); #1;
      check("w8_idle", {bus8.out_valid, bus8.in_ready}, 2'b01);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b0;
      bus8.in_valid = 1'b0;
      bus8.a = '0;
      bus8.b = '0;
      bus8.out_ready = 1'b0;
      acc_v = '0;
`ifdef BOOTH_MAC_EN
      bus.acc_in = '0;
      bus8.acc_in = '0;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst16", {bus.in_ready, bus.out_valid, bus.busy, bus.p},
            {3'b100, 32'h0});
      check("rst8", {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.p},
            {3'b100, 16'h0});
      rst = 1'b0;

      run_one(W'(128), W'(-234), 0, 1'b0);
      run_one(W'(-1268), W'(234), 0, 1'b1);
      run_one(W'(587), W'(720), 0, 1'b1);
      run_one(W'(-32768), W'(-32768), 0, 1'b0);
      run_one(W'(-32768), W'(32767), 0, 1'b0);
      run_one(W'(0), W'(-1), 0, 1'b0);
      run_one(W'(587), W'(720), 5, 1'b1);

      // abort mid-run: rst sampled while count is 3
      bus.a = W'(1234);
      bus.b = W'(-77);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort", {bus.in_ready, bus.out_valid, bus.busy, bus.p},
            {3'b100, 32'h0});
      for (int k = 0; k < W/2 + 2; k++) begin
         @(posedge clk); #1;
         check("no_pulse", bus.out_valid, 0);
      end
      run_one(W'(3), W'(5), 0, 1'b0);

`ifdef BOOTH_MAC_EN
      acc_v = 32'h0000_0010;
      run_one(W'(587), W'(720), 0, 1'b0);
      acc_v = '0;
`endif

      for (int n = 0; n < 24; n++) begin
         acc_v = MAC ? 32'($urandom) : '0;
         run_one(W'($urandom), W'($urandom), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      run8(W8'(-128), W8'(-128));
      for (int n = 0; n < 8; n++)
         run8(W8'($urandom), W8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
